// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared state encoding and default sizes for the arithmetic unit
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } arith_state_t;

  localparam int ARITH_WIDTH     = 10;
  localparam int ARITH_FRAC_BITS = 6;

  function automatic int cnt_bits(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mul_ctrl.sv
// rtl/mul_ctrl.sv - multiplier sequencing FSM: bit counter, busy/valid and datapath strobes
module mul_ctrl
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH,
  localparam int CW   = cnt_bits(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop_early,
  output logic          load,
  output logic          run,
  output logic          finish,
  output logic          busy,
  output logic          valid,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  arith_state_t state, state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (load)     cnt <= '0;
      else if (run) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
          load       = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop_early || cnt == LAST) begin
          state_next = ST_DONE;
          finish     = 1'b1;
        end
      end
      ST_DONE: begin
        // a start seen in the result cycle chains straight into the next operation
        if (start) begin
          state_next = ST_RUN;
          load       = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign run   = (state == ST_RUN);
  assign busy  = (state == ST_RUN);
  assign valid = (state == ST_DONE);

endmodule

// File: rtl/mul_top.sv
// rtl/mul_top.sv - shift-add unsigned fixed-point multiplier, Q = (A*B) >> FRAC_BITS; MUL_EARLY_TERM_EN enables early exit
module mul_top
  import arith_pkg::*;
#(
  parameter int WIDTH     = ARITH_WIDTH,
  parameter int FRAC_BITS = ARITH_FRAC_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             valid,
  output logic             ov
);

  localparam int CW = cnt_bits(WIDTH);

  logic [2*WIDTH-1:0] acc, acc_next, addend;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [CW-1:0]      cnt;
  logic               load, run, finish, stop_early;

`ifdef MUL_EARLY_TERM_EN
  assign stop_early = ~|mplier;
`else
  assign stop_early = 1'b0;
`endif

  mul_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop_early(stop_early),
    .load      (load),
    .run       (run),
    .finish    (finish),
    .busy      (busy),
    .valid     (valid),
    .cnt       (cnt)
  );

  assign addend   = {{WIDTH{1'b0}}, mcand} << cnt;
  assign acc_next = mplier[0] ? (acc + addend) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      Q      <= '0;
      ov     <= 1'b0;
    end else begin
      if (load) begin
        acc    <= '0;
        mcand  <= A;
        mplier <= B;
      end else if (run) begin
        acc    <= acc_next;
        mplier <= mplier >> 1;
      end
      // result registers take the final partial sum so Q/ov are ready in the DONE cycle
      if (finish) begin
        Q  <= acc_next[FRAC_BITS+WIDTH-1:FRAC_BITS];
        ov <= |acc_next[2*WIDTH-1:FRAC_BITS+WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_mul_top.sv
// tb/tb_mul_top.sv - scoreboard bench for mul_top (either MUL_EARLY_TERM_EN setting)
module tb_mul_top;

  localparam int W = 10;
  localparam int F = 6;
`ifdef MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] Q;
  logic         busy, valid, ov;

  int           checks = 0;
  int           fails = 0;
  exp_t         sb[$];
  logic [W-1:0] last_q = '0;
  logic         last_ov = 1'b0;

  mul_top #(.WIDTH(W), .FRAC_BITS(F)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .Q    (Q),
    .busy (busy),
    .valid(valid),
    .ov   (ov)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    exp_t e;
    p    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    e.q  = p[F+W-1:F];
    e.ov = |p[2*W-1:F+W];
    return e;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] b);
    int h;
    h = -1;
    for (int i = 0; i < W; i++) if (b[i]) h = i;
    if (!EARLY) return W + 1;
    if (h < 0) return 2;
    return ((h + 2 < W) ? h + 2 : W) + 1;
  endfunction

  always @(negedge clk) begin
    if (rst_n && valid) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: valid with Q=%h ov=%b, required no result", Q, ov);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (Q !== e.q || ov !== e.ov) begin
          fails++;
          $display("FAIL sb_result: Q=%b ov=%b, required Q=%b ov=%b", Q, ov, e.q, e.ov);
        end
        last_q  = e.q;
        last_ov = e.ov;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    A = a;
    B = b;
    start = 1'b1;
    sb.push_back(model(a, b));
  endtask

  task automatic wait_valid(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) bcnt++;
      if (valid) break;
      if (lat >= 40) begin
        checks++;
        fails++;
        $display("FAIL wait_valid: no valid after %0d cycles, required one", lat);
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (Q !== '0 || ov !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: Q=%h ov=%b busy=%b valid=%b, required all 0", Q, ov, busy, valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b valid=%b, required 0 0", busy, valid);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    @(negedge clk);
    issue(10'b0000110000, 10'b0010000000);
    wait_valid(lat, bc);
    checks++;
    if (lat !== exp_lat(10'b0010000000)) begin
      fails++;
      $display("FAIL basic_latency: %0d, required %0d", lat, exp_lat(10'b0010000000));
    end
    checks++;
    if (bc !== exp_lat(10'b0010000000) - 1) begin
      fails++;
      $display("FAIL basic_busy: %0d cycles, required %0d", bc, exp_lat(10'b0010000000) - 1);
    end
    checks++;
    if (Q !== 10'b0001100000 || ov !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_q: Q=%b ov=%b busy=%b, required 0001100000 0 0", Q, ov, busy);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || Q !== 10'b0001100000) begin
      fails++;
      $display("FAIL basic_hold: valid=%b Q=%b, required 0 0001100000", valid, Q);
    end
  endtask

  task automatic test_overflow();
    int lat, bc;
    @(negedge clk);
    issue(10'b0101110010, 10'b1000000000);
    wait_valid(lat, bc);
    checks++;
    if (Q !== 10'b1110010000 || ov !== 1'b1) begin
      fails++;
      $display("FAIL ovf_8x: Q=%b ov=%b, required 1110010000 1", Q, ov);
    end
    issue(10'b1111111111, 10'b1111111111);
    wait_valid(lat, bc);
    checks++;
    if (Q !== 10'b1111100000 || ov !== 1'b1) begin
      fails++;
      $display("FAIL ovf_max: Q=%b ov=%b, required 1111100000 1", Q, ov);
    end
  endtask

  task automatic test_zero();
    int lat, bc;
    @(negedge clk);
    @(negedge clk);
    issue(10'b1111111111, 10'b0000000000);
    wait_valid(lat, bc);
    checks++;
    if (Q !== '0 || ov !== 1'b0) begin
      fails++;
      $display("FAIL zero_b: Q=%b ov=%b, required 0 0", Q, ov);
    end
    checks++;
    if (lat !== exp_lat('0)) begin
      fails++;
      $display("FAIL zero_latency: %0d, required %0d", lat, exp_lat('0));
    end
    issue(10'b0000000000, 10'b1010101010);
    wait_valid(lat, bc);
    checks++;
    if (Q !== '0 || ov !== 1'b0 || lat !== exp_lat(10'b1010101010)) begin
      fails++;
      $display("FAIL zero_a: Q=%b ov=%b lat=%0d, required 0 0 %0d", Q, ov, lat, exp_lat(10'b1010101010));
    end
  endtask

  task automatic test_busy_ignore();
    int lat, bc;
    logic [W-1:0] held_q;
    @(negedge clk);
    @(negedge clk);
    held_q = last_q;
    issue(10'b0000110000, 10'b0010000000);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    A = 10'b1111111111;
    B = 10'b1111111111;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (busy !== 1'b1 || Q !== held_q) begin
      fails++;
      $display("FAIL ignore_hold: busy=%b Q=%b, required 1 %b", busy, Q, held_q);
    end
    wait_valid(lat, bc);
    checks++;
    if (lat + 4 !== exp_lat(10'b0010000000) || Q !== 10'b0001100000) begin
      fails++;
      $display("FAIL ignore_result: lat=%0d Q=%b, required %0d 0001100000", lat + 4, Q, exp_lat(10'b0010000000));
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    issue(10'b1111111111, 10'b1111111111);
    @(negedge clk); start = 1'b0;
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0 || Q !== 10'b0001100000) begin
      fails++;
      $display("FAIL b2b_accept: busy=%b valid=%b Q=%b, required 1 0 0001100000", busy, valid, Q);
    end
    wait_valid(lat, bc);
    checks++;
    if (lat + 1 !== exp_lat(10'b1111111111) || Q !== 10'b1111100000 || ov !== 1'b1) begin
      fails++;
      $display("FAIL b2b_result: lat=%0d Q=%b ov=%b, required %0d 1111100000 1", lat + 1, Q, ov, exp_lat(10'b1111111111));
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc;
    @(negedge clk);
    @(negedge clk);
    issue(10'b0000110000, 10'b0010000000);
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || Q !== '0 || ov !== 1'b0) begin
      fails++;
      $display("FAIL abort_clear: busy=%b valid=%b Q=%b ov=%b, required all 0", busy, valid, Q, ov);
    end
    sb.delete();
    last_q  = '0;
    last_ov = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bc = 0;
    repeat (15) begin
      @(negedge clk);
      if (valid || busy) bc++;
    end
    checks++;
    if (bc !== 0) begin
      fails++;
      $display("FAIL abort_quiet: %0d active cycles after reset, required 0", bc);
    end
    issue(10'b0000110000, 10'b0010000000);
    wait_valid(lat, bc);
    checks++;
    if (Q !== 10'b0001100000 || ov !== 1'b0 || lat !== exp_lat(10'b0010000000)) begin
      fails++;
      $display("FAIL abort_recover: Q=%b ov=%b lat=%0d, required 0001100000 0 %0d", Q, ov, lat, exp_lat(10'b0010000000));
    end
  endtask

  task automatic test_random();
    int lat, bc, bad;
    logic [W-1:0] a, b;
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 7))
        0:       a = '0;
        1:       a = '1;
        default: a = W'($urandom_range(0, (1 << W) - 1));
      endcase
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = '1;
        2:       b = W'(1) << $urandom_range(0, W - 1);
        default: b = W'($urandom_range(0, (1 << W) - 1));
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(a, b);
      wait_valid(lat, bc);
      checks++;
      if (lat !== exp_lat(b) || bc !== lat - 1) begin
        fails++;
        bad++;
        if (bad < 10)
          $display("FAIL rand_latency: A=%h B=%h lat=%0d busy=%0d, required %0d %0d", a, b, lat, bc, exp_lat(b), exp_lat(b) - 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_random();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL sb_drain: %0d results outstanding, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
